// File: rtl/vga_ctrl.sv
// VGA timing generator and output pipeline: one pixel every two clk cycles, with
// colour, blank and sync registered together one pixel period after the position.
module vga_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  input  logic [7:0] r_data,
  input  logic [7:0] g_data,
  input  logic [7:0] b_data,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       phase_q;
  logic       pix_en;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       active;
  logic       hs_n;
  logic       vs_n;
  logic [7:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, blank_q;

  // phase is high on the second clk of each pixel; that edge advances the pixel.
  assign pix_en = phase_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_comb begin
    active = (h_q < H_VIS) && (v_q < V_VIS);
    hs_n   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_n   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      h_q     <= h_d;
      v_q     <= v_d;
      // Renderer data is only trusted at the pixel edge; mid-pixel changes are ignored.
      if (pix_en) begin
        r_q     <= active ? r_data : 8'h00;
        g_q     <= active ? g_data : 8'h00;
        b_q     <= active ? b_data : 8'h00;
        hs_q    <= hs_n;
        vs_q    <= vs_n;
        blank_q <= active;
      end
    end
  end

  assign x_cnt       = h_q;
  assign y_cnt       = v_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  // DAC samples on the rising edge, mid-way through each two-clk output interval.
  assign vga_clk     = phase_q;
  assign frame_start = pix_en && (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch, in pixels
  H_SYNC, 96, horizontal sync width, in pixels
  H_BP, 48, horizontal back porch, in pixels
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch, in lines
  V_SYNC, 2, vertical sync width, in lines
  V_BP, 33, vertical back porch, in lines
REQ-002 The port list SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  50 MHz system clock; the only clock
  rst  in  1  reset; synchronous, active-high
  x_cnt  out  10  current horizontal position h, 0..H_TOTAL-1, drives the sprite renderers
  y_cnt  out  10  current vertical position v, 0..V_TOTAL-1
  r_data/g_data/b_data  in  8 each  pixel colour returned combinationally by the renderers for (x_cnt, y_cnt)
  vga_r/vga_g/vga_b  out  8 each  registered DAC colour
  vga_hs/vga_vs  out  1 each  sync outputs, active-low
  vga_blank_n  out  1  high during the visible area
  vga_sync_n  out  1  constant 0
  vga_clk  out  1  25 MHz pixel clock to the DAC
  frame_start  out  1  one-clk pulse marking the start of each frame
REQ-003 Reset SHALL be synchronous and active-high on rst, sampled only on the rising edge of clk; there SHALL be no other clock.

Function
REQ-004 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-005 A phase register SHALL toggle every clk, and pix_en SHALL be (phase==1), giving one pixel per two clks.
REQ-006 vga_clk SHALL equal phase, so the DAC rising edge falls mid-way through each stable output interval.
REQ-007 Counter h SHALL advance only on pix_en and wrap from H_TOTAL-1 to 0.
REQ-008 Counter v SHALL increment when h wraps and SHALL itself wrap from V_TOTAL-1 to 0.
REQ-009 x_cnt SHALL equal h and y_cnt SHALL equal v, with no added delay.
REQ-010 active SHALL be (h<H_ACTIVE && v<V_ACTIVE).
REQ-011 On each pix_en edge, vga_r/g/b SHALL load r/g/b_data when active and 0 otherwise.
REQ-012 On each pix_en edge, vga_blank_n SHALL load active.
REQ-013 On each pix_en edge, vga_hs SHALL load 0 when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751] by default) and 1 otherwise.
REQ-014 On each pix_en edge, vga_vs SHALL load 0 when v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491] by default) and 1 otherwise.
REQ-015 Pipeline latency SHALL be exactly one pixel period (2 clks): colour, blank and sync for position (h,v) appear together at the pix_en edge that follows the one that set h,v.
REQ-016 All registered outputs SHALL hold their value on non-pix_en clks.
REQ-017 frame_start SHALL be high for exactly one clk, on the clk where pix_en=1, h=0 and v=0.
REQ-018 The renderer inputs SHALL be treated as combinational from x_cnt/y_cnt and SHALL be sampled only on pix_en edges.
REQ-019 A mid-line change of r/g/b_data between pix_en edges SHALL have no effect on the outputs.
REQ-020 vga_sync_n SHALL be tied to 0.

Reset
REQ-021 While rst=1 at a clk edge, the block SHALL load phase=0, h=0, v=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0 and frame_start=0.
REQ-022 rst asserted mid-frame SHALL abort the frame immediately.
REQ-023 After rst deasserts, the first pix_en SHALL occur on the second clk, with h=0 and v=0 and frame_start pulsing.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  Reset release, rst high 3 clks then low -> x_cnt=0, y_cnt=0, hs=vs=1, blank_n=0; frame_start pulses at clk 2; x_cnt=1 at clk 4.
  Full frame -> exactly 800*525*2 = 840000 clks between frame_start pulses; 96-pixel hs low per line, starting 2 clks after x_cnt=656; vs low for 2 lines from y_cnt=490.
  Constant inputs r=0xAA, g=0x55, b=0xFF -> output equals the input inside the 640x480 window and 0 elsewhere; blank_n high for 640 pixels per visible line.
  Latency, r_data=x_cnt[7:0] -> vga_r at the pix_en edge after x_cnt=5 reads 5; the value at h=639 reads 0x7F; at h=640, vga_r=0.
  Wrap -> h 799->0 increments v; v 524->0 at h 799->0 asserts frame_start; no glitch on hs or vs.
  Reset mid-frame at v=300, h=400 -> next clk h=v=0, rgb=0, hs=vs=1; the frame restarts cleanly.
